// File: rtl/maint_req_scheduler_if.sv
// Maintenance grant handshake between the scheduler and the instruction receiver.
// The scheduler is the master: it presents a typed grant and waits for a
// one-cycle acceptance pulse from the receiver.
interface maint_req_scheduler_if;
  logic       maint_en;
  logic [1:0] maint_type;
  logic       maint_ack;

  modport master (
    output maint_en,
    output maint_type,
    input  maint_ack
  );

  modport slave (
    input  maint_en,
    input  maint_type,
    output maint_ack
  );
endinterface

// File: rtl/maint_req_scheduler.sv
// Maintenance request scheduler: arbitrates auto-refresh, ZQ calibration and
// periodic read into one grant slot, tracks postponed refreshes as a debt
// counter and throttles application traffic while that debt is urgent.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | slot free, pick the highest-priority eligible requester
// S_GRANT     | grant presented, waiting for maint_ack
// S_WAIT_BUSY | grant accepted, waiting for the dispatcher to start
// S_WAIT_IDLE | dispatcher executing the maintenance sequence
// S_DONE      | one-cycle completion: ack pulse or refresh debt decrement
module maint_req_scheduler #(
  parameter int unsigned MAX_DEBT     = 8,
  parameter int unsigned URGENT_TH    = 6,
  parameter int unsigned DEBT_W       = 4,
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  autoref_tick_i,
  input  logic                  zq_req_i,
  input  logic                  pr_rd_req_i,
  input  logic                  app_pending_i,
  input  logic                  dispatcher_busy_i,
  maint_req_scheduler_if.master grant_if,
  output logic                  zq_ack_o,
  output logic                  pr_rd_ack_o,
  output logic                  app_hold_o,
  output logic [DEBT_W-1:0]     aref_debt_o,
  output logic                  aref_overflow_o,
  output logic                  sched_timeout_o
);

  localparam int unsigned TMR_W = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [DEBT_W-1:0] MAX_DEBT_V  = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0] URGENT_TH_V = DEBT_W'(URGENT_TH);
  localparam logic [DEBT_W-1:0] DEBT_ONE    = DEBT_W'(1);
  localparam logic [TMR_W-1:0]  TMO_V       = TMR_W'(WAIT_TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_ONE     = TMR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_BUSY,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    T_AREF = 2'd0,
    T_ZQ   = 2'd1,
    T_PRRD = 2'd2
  } mtype_t;

  state_t            state_q;
  mtype_t            type_q;
  logic              en_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [TMR_W-1:0]  tmr_d;
  logic              zq_ack_q;
  logic              pr_rd_ack_q;
  logic              timeout_q;

  logic [DEBT_W-1:0] debt_q;
  logic [DEBT_W-1:0] debt_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              hold_q;

  logic              refresh_done;
  logic              urgent;
  logic              win_vld;
  mtype_t            win_type;

  // The refresh slot retires one unit of debt in the cycle it completes.
  assign refresh_done = (state_q == S_DONE) && (type_q == T_AREF);
  assign urgent       = (debt_q >= URGENT_TH_V);
  assign tmr_d        = tmr_q + TMR_ONE;

  // Next refresh debt: +tick -done, saturating at MAX_DEBT with a sticky overflow.
  always_comb begin
    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (autoref_tick_i && !refresh_done) begin
      if (debt_q == MAX_DEBT_V) begin
        ovf_d = 1'b1;
      end else begin
        debt_d = debt_q + DEBT_ONE;
      end
    end else if (!autoref_tick_i && refresh_done && (debt_q != '0)) begin
      debt_d = debt_q - DEBT_ONE;
    end
  end

  // Fixed-priority pick: urgent refresh, ZQ, periodic read, then lazy refresh.
  always_comb begin
    win_vld  = 1'b0;
    win_type = T_AREF;
    if (!dispatcher_busy_i) begin
      if (urgent) begin
        win_vld  = 1'b1;
        win_type = T_AREF;
      end else if (zq_req_i) begin
        win_vld  = 1'b1;
        win_type = T_ZQ;
      end else if (pr_rd_req_i) begin
        win_vld  = 1'b1;
        win_type = T_PRRD;
      end else if ((debt_q != '0) && !app_pending_i) begin
        win_vld  = 1'b1;
        win_type = T_AREF;
      end
    end
  end

  // Debt counter, overflow flag and app throttle (hold lags the debt by one cycle).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      debt_q <= '0;
      ovf_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
      hold_q <= urgent;
    end
  end

  // Grant lifecycle FSM with registered grant, completion and timeout outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      type_q      <= T_AREF;
      en_q        <= 1'b0;
      tmr_q       <= '0;
      zq_ack_q    <= 1'b0;
      pr_rd_ack_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      zq_ack_q    <= 1'b0;
      pr_rd_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            type_q  <= win_type;
            en_q    <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Requesters dropping their level here do not withdraw the grant.
          if (grant_if.maint_ack) begin
            en_q    <= 1'b0;
            tmr_q   <= '0;
            state_q <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (dispatcher_busy_i) begin
            state_q <= S_WAIT_IDLE;
          end else begin
            tmr_q <= tmr_d;
            if (tmr_d == TMO_V) begin
              // Dispatcher never started: flag it and retire the grant anyway.
              timeout_q   <= 1'b1;
              zq_ack_q    <= (type_q == T_ZQ);
              pr_rd_ack_q <= (type_q == T_PRRD);
              state_q     <= S_DONE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (!dispatcher_busy_i) begin
            zq_ack_q    <= (type_q == T_ZQ);
            pr_rd_ack_q <= (type_q == T_PRRD);
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_if.maint_en   = en_q;
  assign grant_if.maint_type = type_q;
  assign zq_ack_o            = zq_ack_q;
  assign pr_rd_ack_o         = pr_rd_ack_q;
  assign app_hold_o          = hold_q;
  assign aref_debt_o         = debt_q;
  assign aref_overflow_o     = ovf_q;
  assign sched_timeout_o     = timeout_q;

endmodule
